tree_reduce_ctrl: RTL and testbench
===================================

TREE_REDUCE_CTRL -- requirements
Module: tree_reduce_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of each operand and of the sum.
REQ-002 SHALL have parameter N, default 4: operands per vector; power of two, N >= 2.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port flush  input  1  synchronous abort, return to idle.
REQ-006 SHALL have port in_valid  input  1  operand vector offered.
REQ-007 SHALL have port in_ready  output  1  controller can accept a vector.
REQ-008 SHALL have port in_data  input  WIDTH x [N-1:0] unpacked  operand vector.
REQ-009 SHALL have port out_valid  output  1  sum available.
REQ-010 SHALL have port out_ready  input  1  consumer takes sum.
REQ-011 SHALL have port out_sum  output  WIDTH  reduced sum.
REQ-012 SHALL have port busy  output  1  high whenever state is not S_IDLE.

Function
REQ-013 SHALL time-share one 2-input adder to reduce N operands in exactly N-1 add cycles.
REQ-014 SHALL use states S_IDLE, S_REDUCE, S_DONE; in_ready = (state == S_IDLE); out_valid = (state == S_DONE).
REQ-015 SHALL, on an edge with in_valid && in_ready, load in_data into an N-entry buffer, clear level counter l and pair index j, and go to S_REDUCE.
REQ-016 SHALL, in each S_REDUCE cycle, write buf[j] <= buf[2j] + buf[2j+1] for the current level l.
REQ-017 SHALL increment j; when j reaches (N >> (l+1)) - 1, clear j and increment l; after the final add (l = log2(N)-1, j = 0), go to S_DONE.
REQ-018 SHALL make out_valid rise exactly N-1 cycles after the accepting edge (N=4: 3 cycles).
REQ-019 SHALL drive out_sum = buf[0], stable for the whole of S_DONE.
REQ-020 SHALL hold S_DONE while out_ready = 0; on out_valid && out_ready go to S_IDLE; no overlap of accept with S_DONE.
REQ-021 SHALL ignore in_valid and in_data outside S_IDLE.
REQ-022 SHALL, when flush = 1, go to S_IDLE and clear l, j at the next edge from any state; flush has priority over any handshake in the same cycle.
REQ-023 SHALL keep all additions WIDTH bits, unsigned, with wrap-around modulo 2^WIDTH unless REQ-029 applies.

Reset
REQ-024 SHALL, while rst_n = 0, force state S_IDLE, l = 0, j = 0, and all buffer entries to 0, independent of clk.
REQ-025 SHALL give reset values in_ready = 1, out_valid = 0, busy = 0, out_sum = 0.
REQ-026 SHALL, on reset asserted in S_REDUCE or S_DONE, discard the operation with no output produced.

Configuration
REQ-027 SHALL use macro TREE_REDUCE_SAT_EN.
REQ-028 SHALL, without TREE_REDUCE_SAT_EN, wrap every addition (REQ-023).
REQ-029 SHALL, with TREE_REDUCE_SAT_EN, clamp every individual addition to 2^WIDTH-1 on carry-out; a saturated partial propagates unchanged in later adds.

Structure
REQ-030 SHALL place the state enum typedef (S_IDLE, S_REDUCE, S_DONE) in package tree_reduce_pkg.
REQ-031 SHALL implement the shared adder as sub-module sat_add2 (WIDTH parameter, a, b, sum), with saturation selected by TREE_REDUCE_SAT_EN.
REQ-032 SHALL size l and j as $clog2(N) bits (minimum 1); an elaboration check SHALL reject N < 2 or N not a power of two.

Verification (WIDTH=8, N=4 unless stated)
REQ-033 SHALL cover basic reduce: in_data {1,2,3,4} accepted, out_ready=1 -> out_valid 3 cycles later, out_sum = 10, then in_ready = 1.
REQ-034 SHALL cover overflow: {200,100,0,0} -> out_sum = 44 without macro, 255 with TREE_REDUCE_SAT_EN.
REQ-035 SHALL cover backpressure: out_ready = 0 for 5 cycles in S_DONE -> out_valid and out_sum held; in_valid pulses with {9,9,9,9} ignored, in_ready = 0.
REQ-036 SHALL cover async reset: rst_n low at second S_REDUCE cycle -> immediately busy = 0, in_ready = 1, out_valid never asserted.
REQ-037 SHALL cover flush: flush at second S_REDUCE cycle -> S_IDLE next edge; new {5,5,5,5} then yields 20.
REQ-038 SHALL cover N=8: {1..8} -> out_sum = 36 exactly 7 cycles after accept.

Source files
------------

// File: rtl/tree_reduce_pkg.sv
// Shared types for the tree reduction controller.
package tree_reduce_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REDUCE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Counter width for level/pair indices, never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tree_reduce_ctrl_sat_add2.sv
// Shared two-input adder; TREE_REDUCE_SAT_EN selects clamp-on-carry instead of wrap.
module sat_add2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

`ifdef TREE_REDUCE_SAT_EN
  logic [WIDTH:0] full;

  assign full = {1'b0, a} + {1'b0, b};
  assign sum  = full[WIDTH] ? {WIDTH{1'b1}} : full[WIDTH-1:0];
`else
  assign sum = a + b;
`endif

endmodule

// File: rtl/tree_reduce_ctrl.sv
// Reduces an N-operand vector to one sum using a single time-shared adder in N-1 cycles.
// Build option: TREE_REDUCE_SAT_EN makes every partial add saturate.
module tree_reduce_ctrl
  import tree_reduce_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data [N-1:0],
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             busy
);

  localparam int unsigned LW = idx_w(N);
  localparam logic [LW-1:0] L_LAST = LW'($clog2(N) - 1);

  if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
    $error("tree_reduce_ctrl: N must be a power of two and at least 2");
  end

  state_t           state, state_d;
  logic [LW-1:0]    l, l_d, j, j_d, j_last, ia, ib;
  logic [WIDTH-1:0] bufr [N-1:0];
  logic [WIDTH-1:0] add_sum;
  logic             load, do_add;

  // Pair j at the current level lives at 2j and 2j+1; writes land at j, below any pending read.
  assign ia = LW'(j << 1);
  assign ib = ia + LW'(1);

  sat_add2 #(.WIDTH(WIDTH)) u_add (
    .a   (bufr[ia]),
    .b   (bufr[ib]),
    .sum (add_sum)
  );

  always_comb begin
    state_d = state;
    l_d     = l;
    j_d     = j;
    load    = 1'b0;
    do_add  = 1'b0;
    j_last  = LW'((N >> (32'(l) + 32'd1)) - 32'd1);
    unique case (state)
      S_IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = S_REDUCE;
          l_d     = '0;
          j_d     = '0;
        end
      end
      S_REDUCE: begin
        do_add = 1'b1;
        if (l == L_LAST && j == '0) begin
          state_d = S_DONE;
          l_d     = '0;
          j_d     = '0;
        end else if (j == j_last) begin
          j_d = '0;
          l_d = l + LW'(1);
        end else begin
          j_d = j + LW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort wins over any handshake in the same cycle.
    if (flush) begin
      state_d = S_IDLE;
      l_d     = '0;
      j_d     = '0;
      load    = 1'b0;
      do_add  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      l         <= '0;
      j         <= '0;
      bufr      <= '{default: '0};
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      l         <= l_d;
      j         <= j_d;
      in_ready  <= (state_d == S_IDLE);
      out_valid <= (state_d == S_DONE);
      busy      <= (state_d != S_IDLE);
      if (load) begin
        bufr <= in_data;
      end else if (do_add) begin
        bufr[j] <= add_sum;
      end
    end
  end

  assign out_sum = bufr[0];

endmodule

// File: tb/tb_tree_reduce_ctrl.sv
// Directed bench for tree_reduce_ctrl: N=4 and N=8 instances, hand-computed sums.
module tb_tree_reduce_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0] din [3:0];
  logic [7:0] out_sum;

  logic       in_valid8, in_ready8, out_valid8, busy8;
  logic [7:0] din8 [7:0];
  logic [7:0] out_sum8;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  tree_reduce_ctrl #(.WIDTH(8), .N(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(din),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .busy(busy)
  );

  tree_reduce_ctrl #(.WIDTH(8), .N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(din8),
    .out_valid(out_valid8), .out_ready(1'b1), .out_sum(out_sum8),
    .busy(busy8)
  );

  task automatic check(input string tag, input int got, input int exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send4(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
    din[0] = a; din[1] = b; din[2] = c; din[3] = d;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Counts edges after the accepting edge until out_valid, bounded.
  task automatic wait_done(input string tag, input int exp_lat, input int exp_sum);
    int lat = 0;
    while (!out_valid && lat < 30) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_sum"}, int'(out_sum), exp_sum);
  endtask

  initial begin
    int ov_seen;
    int lat8;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0;
    for (int i = 0; i < 4; i++) din[i] = 8'd0;
    for (int i = 0; i < 8; i++) din8[i] = 8'd0;
    #12;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_out_sum", int'(out_sum), 0);
    step();
    rst_n = 1'b1;
    step();

    // Basic reduce
    send4(8'd1, 8'd2, 8'd3, 8'd4);
    check("basic_busy", int'(busy), 1);
    wait_done("basic", 3, 10);
    step();
    check("basic_in_ready_after", int'(in_ready), 1);

    // Overflow: wraps by default, clamps when saturation is built in
    send4(8'd200, 8'd100, 8'd0, 8'd0);
`ifdef TREE_REDUCE_SAT_EN
    wait_done("overflow", 3, 255);
`else
    wait_done("overflow", 3, 44);
`endif
    step();

    // Backpressure with ignored offers during S_DONE
    out_ready = 1'b0;
    send4(8'd10, 8'd20, 8'd30, 8'd40);
    wait_done("bp", 3, 100);
    for (int k = 0; k < 5; k++) begin
      din[0] = 8'd9; din[1] = 8'd9; din[2] = 8'd9; din[3] = 8'd9;
      in_valid = (k % 2 == 0);
      step();
      check("bp_out_valid_held", int'(out_valid), 1);
      check("bp_out_sum_held", int'(out_sum), 100);
      check("bp_in_ready_low", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp_release_out_valid", int'(out_valid), 0);
    check("bp_release_in_ready", int'(in_ready), 1);
    check("bp_sum_untouched", int'(out_sum), 100);

    // Async reset during the second reduce cycle
    send4(8'd1, 8'd2, 8'd3, 8'd4);
    step();
    rst_n = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_in_ready", int'(in_ready), 1);
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_out_sum", int'(out_sum), 0);
    step();
    rst_n = 1'b1;
    ov_seen = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (out_valid) ov_seen = 1;
    end
    check("arst_no_output", ov_seen, 0);

    // Flush during the second reduce cycle, then a fresh vector
    send4(8'd1, 8'd2, 8'd3, 8'd4);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_busy", int'(busy), 0);
    check("flush_in_ready", int'(in_ready), 1);
    send4(8'd5, 8'd5, 8'd5, 8'd5);
    wait_done("flush_next", 3, 20);
    step();

    // Flush beats an accept in the same cycle
    din[0] = 8'd7; din[1] = 8'd7; din[2] = 8'd7; din[3] = 8'd7;
    in_valid = 1'b1;
    flush = 1'b1;
    step();
    in_valid = 1'b0;
    flush = 1'b0;
    check("flush_prio_busy", int'(busy), 0);
    step();

    // N=8 reduce
    for (int i = 0; i < 8; i++) din8[i] = 8'(i + 1);
    in_valid8 = 1'b1;
    step();
    in_valid8 = 1'b0;
    check("n8_busy", int'(busy8), 1);
    lat8 = 0;
    while (!out_valid8 && lat8 < 30) begin
      step();
      lat8++;
    end
    check("n8_latency", lat8, 7);
    check("n8_sum", int'(out_sum8), 36);
    step();
    check("n8_in_ready_after", int'(in_ready8), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
